beam_sum: RTL and testbench
===========================

# beam_sum

Delay-and-sum output stage of the microphone beamformer. It sits directly downstream of `delay_module` and takes its eight delayed 19-bit PCM channels. It adds the channels enabled by a channel mask in a pipelined adder tree, then scales and saturates the result back to 19 bits. It can also report the beam energy per steering setting, so the controller can sweep `delay_select` and pick the loudest direction.

## Interface
- `N_CH`, 8, number of channels summed (must be 8; the adder tree is 3 levels).
- `PCM_W`, 19, signed PCM width on input and output.
- `SUM_SHIFT`, 3, arithmetic right shift applied to the full sum (0..3).
- `WIN_LOG2`, 10, energy window is 2^WIN_LOG2 beam samples (1..12).
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset.
- `sample_valid`  in  1  one-cycle strobe: all `pcm_in` channels hold a new sample.
- `ch_mask`  in  N_CH  per-channel enable; a masked channel contributes 0.
- `delay_select`  in  5  steering code, the same one driven to `delay_module`; used to frame energy windows.
- `pcm_in`  in  N_CH*PCM_W  flattened delayed PCM; channel k occupies `[k*PCM_W +: PCM_W]`, two's complement.
- `beam_valid`  out  1  one-cycle strobe marking a new `beam_pcm`.
- `beam_pcm`  out  PCM_W  scaled, saturated beam sample.
- `beam_sat`  out  1  high with `beam_valid` when saturation clipped this sample.
- `energy_valid`  out  1  one-cycle strobe marking a completed window (BEAM_ENERGY_EN only).
- `energy`  out  48  sum of `beam_pcm`² over the window, unsigned (BEAM_ENERGY_EN only).
- `energy_tag`  out  5  `delay_select` value the window was measured under (BEAM_ENERGY_EN only).

## Operation
- **Stage 1 (S1):** mask, sign-extend to 20 bits, form 4 pairwise sums.
- **Stage 2 (S2):** 2 sums, 21 bits.
- **Stage 3 (S3):** 1 sum, 22 bits. The tree never overflows internally.
- **Stage 4 (S4):**
  - Round by adding `2^(SUM_SHIFT-1)`; skip the add when `SUM_SHIFT=0`.
  - Arithmetic shift right by `SUM_SHIFT`.
  - Clamp to [-262144, 262143] and set `beam_sat` when the clamp is active.
- A valid bit travels with each stage. Data registers load only when their incoming valid bit is high, so they hold their value otherwise.
- An all-zero `ch_mask` yields `beam_pcm = 0`, with `beam_valid` still pulsing.
- Energy accumulator states:
  - **ACC:** on each `beam_valid`, add `beam_pcm`² to the 48-bit accumulator and increment the sample counter.
  - **DUMP:** on the cycle the counter wraps past 2^WIN_LOG2 - 1:
    - load the accumulator value plus the current square into `energy`;
    - load the latched select into `energy_tag`;
    - pulse `energy_valid`;
    - clear the accumulator and counter.
- A change of `delay_select` is detected against a registered copy. On the cycle it is detected:
  - the partial window is discarded: accumulator and counter clear, and the new select is latched;
  - samples already in flight in S1–S4 count toward the new window.
- Simultaneous events:
  - Change detection on the same cycle as the final sample of a window: the restart wins and no `energy_valid` is produced.
  - `beam_valid` never overlaps itself, so there is no back-pressure. A `sample_valid` on consecutive cycles is accepted at full rate.

## Timing
- Latency: `sample_valid` in cycle t gives `beam_valid` in cycle t+4.
- Throughput: one sample per cycle.
- `energy_valid` is registered: it rises 1 cycle after the `beam_valid` of the final window sample.
- While `rst` is low, and after it is released, all outputs are 0:
  - `beam_valid`, `beam_pcm`, `beam_sat`;
  - `energy_valid`, `energy`, `energy_tag`.
- Reset also clears the valid pipe, the accumulator, the counter and the registered select.
- Asserting reset mid-window or mid-pipeline drops all in-flight samples. No `beam_valid` is emitted for them.

## Configuration
- Macro: `BEAM_ENERGY_EN`.
- When defined: the energy accumulator, counter, select tracking and the `energy*` outputs are present as described above.
- When undefined:
  - no accumulator logic is built;
  - `energy_valid`, `energy` and `energy_tag` are tied to 0 (the ports remain);
  - `delay_select` is unused.

## Structure
- Package `beam_pkg` holds:
  - `PCM_W`, `N_CH`, `ACC_W = 48`, `SEL_W = 5`;
  - typedef `pcm_t` (signed `PCM_W`);
  - typedef `acc_t`.
- Sub-module `beam_energy_acc` contains the square, accumulate, window counter, select change detection and the ACC/DUMP logic. It is instantiated under `BEAM_ENERGY_EN`.

## Test plan
- **Equal inputs:** all channels 1000, mask 0xFF, `SUM_SHIFT=3`, one `sample_valid` → exactly 4 cycles later `beam_pcm = 1000`, `beam_sat = 0`.
- **Partial mask:** mask 0x0F, channels 0–3 = 2000, channels 4–7 = 5000 → `beam_pcm = 1000`. With mask 0x00 → `beam_pcm = 0` and `beam_valid` pulses.
- **Saturation:**
  - all channels 262143, `SUM_SHIFT=0` → `beam_pcm = 262143`, `beam_sat = 1`;
  - all channels -262144, `SUM_SHIFT=3` → `beam_pcm = -262144`, `beam_sat = 0`.
- **Energy window:** `WIN_LOG2=2`, constant `beam_pcm = 1000`, `delay_select = 5` → `energy_valid` every 4 samples, with `energy = 4000000` and `energy_tag = 5`.
- **Steering change:** `delay_select` changes after 2 samples of a window → no `energy_valid` for the partial window; the next `energy_valid` comes 4 samples after the change and carries the new tag.
- **Reset mid-stream:** back-to-back `sample_valid` while `rst` is pulsed low for 1 cycle → all outputs 0, no `beam_valid` for the dropped samples; the first post-reset sample appears 4 cycles after its strobe.

Source files
------------

// File: rtl/beam_pkg.sv
// Shared widths and types for the delay-and-sum beam output stage.
package beam_pkg;
  localparam int N_CH  = 8;
  localparam int PCM_W = 19;
  localparam int ACC_W = 48;
  localparam int SEL_W = 5;

  typedef logic signed [PCM_W-1:0] pcm_t;
  typedef logic [ACC_W-1:0] acc_t;

  typedef enum logic {
    ACC,
    DUMP
  } mode_e;
endpackage

// File: rtl/beam_energy_acc.sv
// Windowed beam energy: square, accumulate, dump per steering setting.
module beam_energy_acc
  import beam_pkg::*;
#(
  parameter int WIN_LOG2 = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             beam_valid,
  input  pcm_t             beam_pcm,
  input  logic [SEL_W-1:0] delay_select,
  output logic             energy_valid,
  output acc_t             energy,
  output logic [SEL_W-1:0] energy_tag
);
  typedef logic [WIN_LOG2-1:0] cnt_t;

  logic signed [2*PCM_W-1:0] sq_s;
  acc_t sq, acc_q, acc_n, en_n;
  cnt_t cnt_q, cnt_n;
  logic [SEL_W-1:0] sel_q, sel_n, tag_n;
  logic ev_n, chg;
  mode_e mode;

  assign sq_s = (2*PCM_W)'(beam_pcm) * (2*PCM_W)'(beam_pcm);
  assign sq   = {{(ACC_W-2*PCM_W){1'b0}}, sq_s};
  assign chg  = delay_select != sel_q;

  // A steering change restarts the window; the sample on
  // the output this cycle is the first of the new window.
  always_comb begin
    acc_n = acc_q;
    cnt_n = cnt_q;
    sel_n = sel_q;
    en_n  = energy;
    tag_n = energy_tag;
    ev_n  = 1'b0;
    mode  = ACC;
    if (!chg && beam_valid && (&cnt_q)) mode = DUMP;
    if (chg) begin
      sel_n = delay_select;
      acc_n = beam_valid ? sq : '0;
      cnt_n = cnt_t'(beam_valid);
    end else if (beam_valid) begin
      unique case (mode)
        DUMP: begin
          en_n  = acc_q + sq;
          tag_n = sel_q;
          ev_n  = 1'b1;
          acc_n = '0;
          cnt_n = '0;
        end
        default: begin
          acc_n = acc_q + sq;
          cnt_n = cnt_q + cnt_t'(1);
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q        <= '0;
      cnt_q        <= '0;
      sel_q        <= '0;
      energy_valid <= 1'b0;
      energy       <= '0;
      energy_tag   <= '0;
    end else begin
      acc_q        <= acc_n;
      cnt_q        <= cnt_n;
      sel_q        <= sel_n;
      energy_valid <= ev_n;
      energy       <= en_n;
      energy_tag   <= tag_n;
    end
  end
endmodule

// File: rtl/beam_sum.sv
// Masked 8-channel adder tree with round/shift/saturate output stage.
// Optional windowed energy reporting under `BEAM_ENERGY_EN`.
module beam_sum #(
  parameter int N_CH      = 8,
  parameter int PCM_W     = 19,
  parameter int SUM_SHIFT = 3,
  parameter int WIN_LOG2  = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sample_valid,
  input  logic [N_CH-1:0]              ch_mask,
  input  logic [beam_pkg::SEL_W-1:0]   delay_select,
  input  logic [N_CH*PCM_W-1:0]        pcm_in,
  output logic                         beam_valid,
  output logic signed [PCM_W-1:0]      beam_pcm,
  output logic                         beam_sat,
  output logic                         energy_valid,
  output logic [beam_pkg::ACC_W-1:0]   energy,
  output logic [beam_pkg::SEL_W-1:0]   energy_tag
);
  import beam_pkg::*;

  localparam int W1   = PCM_W + 1;
  localparam int W2   = PCM_W + 2;
  localparam int W3   = PCM_W + 3;
  localparam int RND  = (1 << SUM_SHIFT) >> 1;
  localparam int MAXV = (1 << (PCM_W - 1)) - 1;
  localparam int MINV = -(1 << (PCM_W - 1));

  logic signed [W1-1:0] lane [N_CH];
  logic signed [W1-1:0] s1 [4];
  logic signed [W2-1:0] s2 [2];
  logic signed [W3-1:0] s3, rnd, shd;
  logic s1_v, s2_v, s3_v, sat_n;
  logic signed [PCM_W-1:0] pcm_n;

  always_comb begin
    for (int k = 0; k < N_CH; k++)
      lane[k] = ch_mask[k] ?
        W1'($signed(pcm_in[k*PCM_W +: PCM_W])) : '0;
  end

  // Widths grow one bit per level, so the tree cannot overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
      s3_v <= 1'b0;
      for (int i = 0; i < 4; i++) s1[i] <= '0;
      for (int i = 0; i < 2; i++) s2[i] <= '0;
      s3 <= '0;
    end else begin
      s1_v <= sample_valid;
      s2_v <= s1_v;
      s3_v <= s2_v;
      if (sample_valid)
        for (int i = 0; i < 4; i++)
          s1[i] <= lane[2*i] + lane[2*i+1];
      if (s1_v)
        for (int i = 0; i < 2; i++)
          s2[i] <= W2'(s1[2*i]) + W2'(s1[2*i+1]);
      if (s2_v)
        s3 <= W3'(s2[0]) + W3'(s2[1]);
    end
  end

  always_comb begin
    rnd   = s3 + W3'(RND);
    shd   = rnd >>> SUM_SHIFT;
    sat_n = 1'b0;
    pcm_n = shd[PCM_W-1:0];
    if (int'(shd) > MAXV) begin
      sat_n = 1'b1;
      pcm_n = PCM_W'(MAXV);
    end else if (int'(shd) < MINV) begin
      sat_n = 1'b1;
      pcm_n = PCM_W'(MINV);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beam_valid <= 1'b0;
      beam_pcm   <= '0;
      beam_sat   <= 1'b0;
    end else begin
      beam_valid <= s3_v;
      beam_sat   <= s3_v & sat_n;
      if (s3_v) beam_pcm <= pcm_n;
    end
  end

`ifdef BEAM_ENERGY_EN
  beam_energy_acc #(
    .WIN_LOG2(WIN_LOG2)
  ) u_acc (
    .clk(clk),
    .rst(rst),
    .beam_valid(beam_valid),
    .beam_pcm(beam_pcm),
    .delay_select(delay_select),
    .energy_valid(energy_valid),
    .energy(energy),
    .energy_tag(energy_tag)
  );
`else
  logic sel_unused;
  assign sel_unused   = ^delay_select;
  assign energy_valid = 1'b0;
  assign energy       = '0;
  assign energy_tag   = '0;
`endif
endmodule

// File: tb/tb_beam_sum.sv
// Bench for beam_sum: directed vector table, steering/reset sequences,
// and random traffic against a reference model.
module tb_beam_sum;
`ifdef BEAM_ENERGY_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif
  localparam longint M48 = (longint'(1) << 48) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sample_valid = 1'b0;
  logic [7:0] ch_mask = '0;
  logic [4:0] delay_select = '0;
  logic [8*19-1:0] pcm_in;
  int chv [8];

  logic bv0, bs0, ev0, bv1, bs1, ev1;
  logic signed [18:0] bp0, bp1;
  logic [47:0] en0, en1;
  logic [4:0] tg0, tg1;

  always #5 clk = ~clk;

  always_comb begin
    for (int k = 0; k < 8; k++) pcm_in[k*19 +: 19] = chv[k][18:0];
  end

  beam_sum #(.N_CH(8), .PCM_W(19), .SUM_SHIFT(3), .WIN_LOG2(2)) u0 (
    .clk(clk), .rst(rst), .sample_valid(sample_valid),
    .ch_mask(ch_mask), .delay_select(delay_select), .pcm_in(pcm_in),
    .beam_valid(bv0), .beam_pcm(bp0), .beam_sat(bs0),
    .energy_valid(ev0), .energy(en0), .energy_tag(tg0));

  beam_sum #(.N_CH(8), .PCM_W(19), .SUM_SHIFT(0), .WIN_LOG2(2)) u1 (
    .clk(clk), .rst(rst), .sample_valid(sample_valid),
    .ch_mask(ch_mask), .delay_select(delay_select), .pcm_in(pcm_in),
    .beam_valid(bv1), .beam_pcm(bp1), .beam_sat(bs1),
    .energy_valid(ev1), .energy(en1), .energy_tag(tg1));

  int total = 0;
  int bad = 0;
  int cyc = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", nm, cyc, act, exp);
    end
  endtask

  function automatic void ref_beam(input int shift, input logic [7:0] m,
                                   output int p, output bit s);
    int sum;
    sum = 0;
    for (int k = 0; k < 8; k++) if (m[k]) sum += chv[k];
    if (shift > 0) sum += 1 << (shift - 1);
    sum = sum >>> shift;
    s = 1'b0;
    p = sum;
    if (sum > 262143) begin p = 262143; s = 1'b1; end
    else if (sum < -262144) begin p = -262144; s = 1'b1; end
  endfunction

  function automatic int rnd_pcm();
    logic signed [18:0] r;
    r = 19'($urandom);
    return int'(r);
  endfunction

  typedef struct {
    int due; int p3; bit s3; int p0; bit s0;
  } exp_t;
  exp_t q[$];
  longint win[$];
  int m_sel = 0;
  bit pend_ev = 1'b0;
  longint pend_e = 0;
  int pend_t = 0;
  longint held_e = 0;
  int held_t = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge rst) begin
    q.delete();
    win.delete();
    m_sel = 0;
    pend_ev = 1'b0;
    held_e = 0;
    held_t = 0;
  end

  always @(negedge clk) begin
    exp_t e;
    bit has;
    longint acc;
    if (!rst) begin
      chk("rst_beam0", {bv0, bs0, bp0}, 0);
      chk("rst_energy0", {ev0, tg0, en0}, 0);
      chk("rst_beam1", {bv1, bs1, bp1}, 0);
      chk("rst_energy1", {ev1, tg1, en1}, 0);
    end else begin
      has = q.size() > 0 && q[0].due == cyc;
      e = '{0, 0, 1'b0, 0, 1'b0};
      if (has) e = q.pop_front();
      chk("beam_valid0", bv0, has);
      chk("beam_valid1", bv1, has);
      if (has) begin
        chk("beam_pcm0", bp0, e.p3);
        chk("beam_sat0", bs0, e.s3);
        chk("beam_pcm1", bp1, e.p0);
        chk("beam_sat1", bs1, e.s0);
      end
      if (pend_ev && EN) begin
        held_e = pend_e;
        held_t = pend_t;
      end
      chk("energy_valid", ev0, pend_ev && EN);
      chk("energy", en0, held_e);
      chk("energy_tag", tg0, held_t);
      pend_ev = 1'b0;
      if (int'(delay_select) != m_sel) begin
        win.delete();
        if (has) win.push_back(longint'(e.p3) * e.p3);
        m_sel = delay_select;
      end else if (has) begin
        win.push_back(longint'(e.p3) * e.p3);
        if (win.size() == 4) begin
          acc = 0;
          foreach (win[i]) acc += win[i];
          pend_ev = 1'b1;
          pend_e = acc & M48;
          pend_t = m_sel;
          win.delete();
        end
      end
      if (sample_valid) begin
        ref_beam(3, ch_mask, e.p3, e.s3);
        ref_beam(0, ch_mask, e.p0, e.s0);
        e.due = cyc + 4;
        q.push_back(e);
      end
    end
  end

  typedef struct {
    logic [7:0] m; int lo; int hi; int p3; bit s3; int p0; bit s0;
  } vec_t;
  vec_t tv [10];

  task automatic set_ch(input int lo, input int hi);
    for (int k = 0; k < 8; k++) chv[k] = (k < 4) ? lo : hi;
  endtask

  initial begin
    int pulses, last_t, n;
    longint last_e;
    tv[0] = '{8'hFF, 1000, 1000, 1000, 0, 8000, 0};
    tv[1] = '{8'h0F, 2000, 5000, 1000, 0, 8000, 0};
    tv[2] = '{8'h00, 2000, 5000, 0, 0, 0, 0};
    tv[3] = '{8'hFF, 262143, 262143, 262143, 0, 262143, 1};
    tv[4] = '{8'hFF, -262144, -262144, -262144, 0, -262144, 1};
    tv[5] = '{8'hFF, -300, 400, 50, 0, 400, 0};
    tv[6] = '{8'h07, 1, 1, 0, 0, 3, 0};
    tv[7] = '{8'h0F, 1, 1, 1, 0, 4, 0};
    tv[8] = '{8'h1F, -1, -1, -1, 0, -5, 0};
    tv[9] = '{8'hF0, -262144, 262143, 131072, 0, 262143, 1};
    set_ch(0, 0);

    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);

    foreach (tv[i]) begin
      #1;
      set_ch(tv[i].lo, tv[i].hi);
      ch_mask = tv[i].m;
      sample_valid = 1'b1;
      @(posedge clk);
      #1 sample_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("vec_valid", bv0, 1);
      chk("vec_pcm0", bp0, tv[i].p3);
      chk("vec_sat0", bs0, tv[i].s3);
      chk("vec_pcm1", bp1, tv[i].p0);
      chk("vec_sat1", bs1, tv[i].s0);
      @(posedge clk);
    end

    // energy window under select 5
    #1 rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    delay_select = 5;
    set_ch(1000, 1000);
    ch_mask = 8'hFF;
    repeat (4) begin
      sample_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    sample_valid = 1'b0;
    n = 0;
    while (!ev0 && n < 20) begin
      @(negedge clk);
      n++;
    end
`ifdef BEAM_ENERGY_EN
    chk("win_seen", ev0, 1);
    chk("win_energy", en0, 4000000);
    chk("win_tag", tg0, 5);
`endif
    @(posedge clk);

    // steering change after a partial window
    #1;
    repeat (2) begin
      sample_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    sample_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1 delay_select = 7;
    pulses = 0;
    last_t = 0;
    last_e = 0;
    for (int k = 0; k < 34; k++) begin
      @(negedge clk);
      if (ev0) begin
        pulses++;
        last_t = tg0;
        last_e = en0;
      end
      @(posedge clk);
      #1 sample_valid = (k >= 2 && k < 6);
    end
    sample_valid = 1'b0;
`ifdef BEAM_ENERGY_EN
    chk("steer_pulses", pulses, 1);
    chk("steer_tag", last_t, 7);
    chk("steer_energy", last_e, 4000000);
`endif

    // reset pulse in the middle of a back-to-back stream
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      sample_valid = 1'b1;
      for (int c = 0; c < 8; c++) chv[c] = rnd_pcm();
      if (k == 4) rst = 1'b0;
      if (k == 5) rst = 1'b1;
    end
    @(posedge clk);
    #1 sample_valid = 1'b0;
    repeat (6) @(posedge clk);

    // random traffic
    #1 delay_select = 9;
    for (int k = 0; k < 400; k++) begin
      sample_valid = ($urandom_range(0, 3) != 0);
      ch_mask = 8'($urandom);
      if ($urandom_range(0, 7) == 0)
        for (int c = 0; c < 8; c++)
          chv[c] = $urandom_range(0, 1) ? 262143 : -262144;
      else
        for (int c = 0; c < 8; c++) chv[c] = rnd_pcm();
      @(posedge clk);
      #1;
    end
    sample_valid = 1'b0;
    repeat (10) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
    $fatal(1, "timeout");
  end
endmodule
